// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the MEM/WB result and the multdiv result onto the single
// regfile write port, with a 1-entry multdiv hold buffer and a pending-write scoreboard.
//
// state   | meaning
// EMPTY   | hold buffer free, md_ready=1
// HELD    | multdiv result parked in hold, waiting to win the write port
module writeback_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [4:0]  STATUS_REG   = 5'd30
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_rd,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic        md_exception,
  input  logic [31:0] md_exc_code,
  input  logic [4:0]  dec_rs_a,
  input  logic [4:0]  dec_rs_b,
  input  logic [4:0]  dec_rd,
  output logic        hazard_stall,
  output logic        stall_req,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_LIMIT - 1);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HELD  = 1'b1;

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_PIPE = 2'd1;
  localparam logic [1:0] W_HOLD = 2'd2;
  localparam logic [1:0] W_MD   = 2'd3;

  logic [0:0]    state_q, state_d;
  logic [4:0]    hold_rd_q, hold_rd_d;
  logic [4:0]    hold_orig_q, hold_orig_d;
  logic [31:0]   hold_data_q, hold_data_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   sb_q, sb_d;

  logic          md_xfer, pipe_xfer;
  logic [4:0]    md_cap_rd;
  logic [31:0]   md_cap_data;
  logic [1:0]    win;
  logic [4:0]    win_rd, win_orig;
  logic [31:0]   win_data;
  logic          win_is_md, win_we;

  assign md_ready    = (state_q == S_EMPTY);
  assign pipe_ready  = ~stall_q;
  assign md_xfer     = md_valid & md_ready;
  assign pipe_xfer   = pipe_valid & pipe_ready;
  assign md_cap_rd   = md_exception ? STATUS_REG : md_rd;
  assign md_cap_data = md_exception ? md_exc_code : md_data;

  // stall_q only ever rises while HELD, so the hold entry is valid whenever it wins here
  always_comb begin
    win = W_NONE;
    if (stall_q)                 win = W_HOLD;
    else if (pipe_xfer)          win = W_PIPE;
    else if (state_q == S_HELD)  win = W_HOLD;
    else if (md_xfer)            win = W_MD;
  end

  always_comb begin
    win_rd   = 5'd0;
    win_orig = 5'd0;
    win_data = 32'd0;
    case (win)
      W_PIPE: begin
        win_rd   = pipe_rd;
        win_data = pipe_data;
      end
      W_HOLD: begin
        win_rd   = hold_rd_q;
        win_orig = hold_orig_q;
        win_data = hold_data_q;
      end
      W_MD: begin
        win_rd   = md_cap_rd;
        win_orig = md_rd;
        win_data = md_cap_data;
      end
      default: ;
    endcase
  end

  assign win_is_md = (win == W_HOLD) || (win == W_MD);
  assign win_we    = (win != W_NONE) && (win_rd != 5'd0);

  // An r0 winner still consumes its slot but leaves the port address/data untouched
  always_comb begin
    we_d    = win_we;
    wreg_d  = win_we ? win_rd : wreg_q;
    wdata_d = win_we ? win_data : wdata_q;
  end

  always_comb begin
    state_d     = state_q;
    hold_rd_d   = hold_rd_q;
    hold_orig_d = hold_orig_q;
    hold_data_d = hold_data_q;
    starve_d    = starve_q;
    stall_d     = stall_q;
    case (state_q)
      S_EMPTY: begin
        if (win == W_PIPE && md_xfer) begin
          state_d     = S_HELD;
          hold_rd_d   = md_cap_rd;
          hold_orig_d = md_rd;
          hold_data_d = md_cap_data;
          starve_d    = '0;
        end
      end
      S_HELD: begin
        if (win == W_HOLD) begin
          state_d  = S_EMPTY;
          starve_d = '0;
          stall_d  = 1'b0;
        end else begin
          starve_d = starve_q + 1'b1;
          if (starve_q == STARVE_LAST) stall_d = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Clear before set so a same-cycle issue to the retiring register stays pending
  always_comb begin
    sb_d = sb_q;
    if (win_we && win_is_md) begin
      sb_d[win_rd]   = 1'b0;
      sb_d[win_orig] = 1'b0;
    end
    if (md_issue && md_issue_rd != 5'd0) sb_d[md_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  assign hazard_stall = sb_q[dec_rs_a] | sb_q[dec_rs_b] | sb_q[dec_rd];

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= S_EMPTY;
      hold_rd_q   <= 5'd0;
      hold_orig_q <= 5'd0;
      hold_data_q <= 32'd0;
      starve_q    <= '0;
      stall_q     <= 1'b0;
      we_q        <= 1'b0;
      wreg_q      <= 5'd0;
      wdata_q     <= 32'd0;
      sb_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      hold_rd_q   <= hold_rd_d;
      hold_orig_q <= hold_orig_d;
      hold_data_q <= hold_data_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      sb_q        <= sb_d;
    end
  end

  assign stall_req        = stall_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_writeback_arbiter;

  localparam int STARVE = 4;
  localparam logic [4:0] STATUS = 5'd30;

  logic        clock;
  logic        rst_n;
  logic        pipe_valid, pipe_ready;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid, md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_exception;
  logic [31:0] md_exc_code;
  logic [4:0]  dec_rs_a, dec_rs_b, dec_rd;
  logic        hazard_stall, stall_req, ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int total = 0;
  int bad = 0;

  writeback_arbiter #(.STARVE_LIMIT(STARVE), .STATUS_REG(STATUS)) dut (
    .clock(clock), .ctrl_reset_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .md_exception(md_exception), .md_exc_code(md_exc_code),
    .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b), .dec_rd(dec_rd),
    .hazard_stall(hazard_stall), .stall_req(stall_req),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a parked multdiv result, how many times it has lost, a pending set.
  bit          m_hold_v;
  logic [4:0]  m_hold_rd, m_hold_orig;
  logic [31:0] m_hold_data;
  int          m_losses;
  bit          m_stall;
  bit          m_pending [32];
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  task automatic model_reset();
    m_hold_v = 0; m_hold_rd = 0; m_hold_orig = 0; m_hold_data = 0;
    m_losses = 0; m_stall = 0;
    foreach (m_pending[i]) m_pending[i] = 0;
    m_we = 0; m_reg = 0; m_data = 0;
  endtask

  task automatic model_step();
    bit was_held, was_stalled, pipe_taken, md_taken, from_md, hold_won;
    logic [4:0]  w_rd, w_orig, in_rd;
    logic [31:0] w_data, in_data;
    bit have_winner;
    was_held    = m_hold_v;
    was_stalled = m_stall;
    pipe_taken  = pipe_valid && !was_stalled;
    md_taken    = md_valid && !was_held;
    in_rd       = md_exception ? STATUS : md_rd;
    in_data     = md_exception ? md_exc_code : md_data;
    have_winner = 0; from_md = 0; hold_won = 0;
    w_rd = 0; w_orig = 0; w_data = 0;
    if (was_stalled || (!pipe_taken && was_held)) begin
      have_winner = 1; from_md = 1; hold_won = 1;
      w_rd = m_hold_rd; w_orig = m_hold_orig; w_data = m_hold_data;
    end else if (pipe_taken) begin
      have_winner = 1;
      w_rd = pipe_rd; w_data = pipe_data;
      if (was_held) begin
        m_losses++;
        if (m_losses >= STARVE) m_stall = 1;
      end else if (md_taken) begin
        m_hold_v = 1; m_hold_rd = in_rd; m_hold_orig = md_rd; m_hold_data = in_data;
        m_losses = 0;
      end
    end else if (md_taken) begin
      have_winner = 1; from_md = 1;
      w_rd = in_rd; w_orig = md_rd; w_data = in_data;
    end
    m_we = have_winner && (w_rd != 0);
    if (m_we) begin
      m_reg = w_rd;
      m_data = w_data;
    end
    if (hold_won) begin
      m_hold_v = 0; m_losses = 0; m_stall = 0;
    end
    if (m_we && from_md) begin
      m_pending[w_rd] = 0;
      m_pending[w_orig] = 0;
    end
    if (md_issue && md_issue_rd != 0) m_pending[md_issue_rd] = 1;
    m_pending[0] = 0;
  endtask

  initial model_reset();

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Every negedge: registered outputs against the model, combinational ones against current inputs
  always @(negedge clock) begin
    chk("we", {31'd0, ctrl_writeEnable}, {31'd0, m_we});
    chk("reg", {27'd0, ctrl_writeReg}, {27'd0, m_reg});
    chk("data", data_writeReg, m_data);
    chk("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
    chk("md_ready", {31'd0, md_ready}, {31'd0, !m_hold_v});
    chk("pipe_ready", {31'd0, pipe_ready}, {31'd0, !m_stall});
    chk("hazard", {31'd0, hazard_stall},
        {31'd0, m_pending[dec_rs_a] || m_pending[dec_rs_b] || m_pending[dec_rd]});
  end

  task automatic set_idle();
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    md_issue = 0; md_issue_rd = 0;
    md_valid = 0; md_rd = 0; md_data = 0; md_exception = 0; md_exc_code = 0;
    dec_rs_a = 0; dec_rs_b = 0; dec_rd = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Parks r9 behind pipe traffic and drives it to the point where stall_req is asserted
  task automatic starve_hold(input string tag);
    pipe_valid = 1; pipe_rd = 5'd1; pipe_data = 32'h1111;
    md_valid = 1; md_rd = 5'd9; md_data = 32'h9999_0009;
    tick();
    md_valid = 0;
    for (int i = 1; i <= STARVE; i++) begin
      pipe_rd = 5'(10 + i); pipe_data = 32'(i);
      tick();
      if (i == STARVE - 1) chk({tag, "_stall_early"}, {31'd0, stall_req}, 32'd0);
    end
    chk({tag, "_stall_up"}, {31'd0, stall_req}, 32'd1);
    chk({tag, "_pipe_ready_low"}, {31'd0, pipe_ready}, 32'd0);
  endtask

  initial begin
    set_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
    chk("rst_pipe_ready", {31'd0, pipe_ready}, 32'd1);
    @(negedge clock); #2 rst_n = 1'b1;

    // pipe only
    @(posedge clock); #1;
    pipe_valid = 1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    set_idle();
    chk("t1_we", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("t1_reg", {27'd0, ctrl_writeReg}, 32'd5);
    chk("t1_data", data_writeReg, 32'hDEADBEEF);
    tick();
    chk("t1_we_drop", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("t1_data_keep", data_writeReg, 32'hDEADBEEF);

    // collision
    pipe_valid = 1; pipe_rd = 5'd3; pipe_data = 32'hA3;
    md_valid = 1; md_rd = 5'd7; md_data = 32'hB7;
    tick();
    set_idle();
    chk("t2_reg_pipe", {27'd0, ctrl_writeReg}, 32'd3);
    chk("t2_md_ready_low", {31'd0, md_ready}, 32'd0);
    tick();
    chk("t2_reg_md", {27'd0, ctrl_writeReg}, 32'd7);
    chk("t2_data_md", data_writeReg, 32'hB7);
    chk("t2_we_md", {31'd0, ctrl_writeEnable}, 32'd1);

    // starvation
    starve_hold("t3");
    tick();
    set_idle();
    chk("t3_reg9", {27'd0, ctrl_writeReg}, 32'd9);
    chk("t3_data9", data_writeReg, 32'h9999_0009);
    chk("t3_stall_down", {31'd0, stall_req}, 32'd0);
    tick(); tick();

    // exception redirect
    md_issue = 1; md_issue_rd = 5'd12;
    tick();
    md_issue_rd = STATUS;
    tick();
    md_issue = 0; dec_rs_a = 5'd12; dec_rd = STATUS;
    #1 chk("t4_hazard_set", {31'd0, hazard_stall}, 32'd1);
    md_valid = 1; md_rd = 5'd12; md_data = 32'h55; md_exception = 1; md_exc_code = 32'h1;
    tick();
    md_valid = 0; md_exception = 0;
    chk("t4_reg30", {27'd0, ctrl_writeReg}, 32'd30);
    chk("t4_data", data_writeReg, 32'h1);
    #1 chk("t4_hazard_clr", {31'd0, hazard_stall}, 32'd0);

    // scoreboard
    set_idle();
    md_issue = 1; md_issue_rd = 5'd0;
    tick();
    md_issue = 0;
    #1 chk("t5_r0_noset", {31'd0, hazard_stall}, 32'd0);
    md_issue = 1; md_issue_rd = 5'd8;
    tick();
    md_issue = 0; dec_rs_b = 5'd8;
    #1 chk("t5_hazard_on", {31'd0, hazard_stall}, 32'd1);
    tick(); tick();
    chk("t5_hazard_hold", {31'd0, hazard_stall}, 32'd1);
    md_valid = 1; md_rd = 5'd8; md_data = 32'h88;
    tick();
    md_valid = 0;
    chk("t5_reg8", {27'd0, ctrl_writeReg}, 32'd8);
    #1 chk("t5_hazard_off", {31'd0, hazard_stall}, 32'd0);

    // async reset while HELD with stall_req up
    set_idle();
    md_issue = 1; md_issue_rd = 5'd20;
    tick();
    md_issue = 0; dec_rs_a = 5'd20;
    starve_hold("t6");
    chk("t6_hazard_pre", {31'd0, hazard_stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we", {31'd0, ctrl_writeEnable}, 32'd0);
    chk("t6_reg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("t6_data", data_writeReg, 32'd0);
    chk("t6_stall", {31'd0, stall_req}, 32'd0);
    chk("t6_md_ready", {31'd0, md_ready}, 32'd1);
    chk("t6_pipe_ready", {31'd0, pipe_ready}, 32'd1);
    chk("t6_hazard", {31'd0, hazard_stall}, 32'd0);
    set_idle();
    @(negedge clock); #2 rst_n = 1'b1;
    @(posedge clock); #1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      pipe_valid   = ($urandom_range(0, 99) < 55);
      pipe_rd      = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      pipe_data    = $urandom;
      md_valid     = ($urandom_range(0, 99) < 35);
      md_rd        = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      md_data      = $urandom;
      md_exception = ($urandom_range(0, 9) == 0);
      md_exc_code  = $urandom;
      md_issue     = ($urandom_range(0, 99) < 30);
      md_issue_rd  = ($urandom_range(0, 7) == 0) ? STATUS : 5'($urandom_range(0, 15));
      dec_rs_a     = 5'($urandom_range(0, 15));
      dec_rs_b     = 5'($urandom_range(0, 15));
      dec_rd       = ($urandom_range(0, 7) == 0) ? STATUS : 5'($urandom_range(0, 15));
      tick();
    end
    set_idle();
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
